// File: rtl/spi_seq_pkg.sv
// ============================================================================
// Module      : spi_seq_pkg
// Description : Shared state encoding and default parameter values for the
//               SPI frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_seq_pkg;

  localparam int DEF_MAX_BYTES      = 4;
  localparam int DEF_START_HOLD     = 8;
  localparam int DEF_GAP_CYCLES     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_GAP     = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ============================================================================
// Module      : sync_edge_det
// Description : Two-flop synchronizer followed by a rising-edge detector for a
//               flag arriving from a foreign clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  // Bring the flag into this domain, keep one extra stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= async_in;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign rise = r_sync & ~r_sync_d;

endmodule

`default_nettype wire

// File: rtl/spi_frame_sequencer.sv
// ============================================================================
// Module      : spi_frame_sequencer
// Description : Sends multi-byte register frames through the SPI byte engine,
//               MSB byte first, and gathers the returned bytes into one
//               response word with completion / error / timeout reporting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_frame_sequencer
  import spi_seq_pkg::*;
#(
  parameter int MAX_BYTES      = DEF_MAX_BYTES,
  parameter int START_HOLD     = DEF_START_HOLD,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   mainclk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_len,
  input  logic [8*MAX_BYTES-1:0] cmd_data,
  output logic                   spi_enable,
  output logic                   spi_start,
  output logic [7:0]             spi_tx,
  input  logic [7:0]             spi_rx,
  input  logic                   spi_finish,
  output logic                   rsp_valid,
  output logic [8*MAX_BYTES-1:0] rsp_data,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int c_dw = 8 * MAX_BYTES;
  localparam int c_iw = $clog2(MAX_BYTES + 1);
  localparam int c_hw = $clog2(START_HOLD + 1);
  localparam int c_gw = $clog2(GAP_CYCLES + 1);
  localparam int c_tw = $clog2(TIMEOUT_CYCLES);

  localparam logic [c_hw-1:0] c_hold_last = c_hw'(START_HOLD - 1);
  localparam logic [c_gw-1:0] c_gap_last  = c_gw'(GAP_CYCLES - 1);
  localparam logic [c_tw-1:0] c_to_last   = c_tw'(TIMEOUT_CYCLES - 1);

  seq_state_t      r_state;
  logic [c_dw-1:0] r_tx_buf;
  logic [c_dw-1:0] r_rx_shift;
  logic [2:0]      r_len;
  logic [c_iw-1:0] r_byte_idx;
  logic [c_hw-1:0] r_hold_cnt;
  logic [c_gw-1:0] r_gap_cnt;
  logic [c_tw-1:0] r_to_cnt;

  logic            w_fin_rise;
  logic            w_len_bad;
  logic            w_last_byte;
  logic [c_dw-1:0] w_tx_aligned;
  logic [c_dw-1:0] w_rx_next;

  sync_edge_det u_fin_sync (
    .clk      (mainclk),
    .rst_n    (reset_n),
    .async_in (spi_finish),
    .rise     (w_fin_rise)
  );

  // Frame decode: length check, left-align tx bytes so the first one sits on top
  always_comb begin
    w_len_bad    = (cmd_len == 3'd0) || (int'(cmd_len) > MAX_BYTES);
    w_tx_aligned = '0;
    if (!w_len_bad) begin
      w_tx_aligned = cmd_data << (8 * (MAX_BYTES - int'(cmd_len)));
    end
    w_last_byte = (int'(r_byte_idx) == (int'(r_len) - 1));
    w_rx_next   = {r_rx_shift[c_dw-9:0], spi_rx};
  end

  // Frame sequencing FSM with registered outputs, counters and rx shift register
  always_ff @(posedge mainclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_tx_buf   <= '0;
      r_rx_shift <= '0;
      r_len      <= '0;
      r_byte_idx <= '0;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_to_cnt   <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      spi_enable <= 1'b0;
      spi_start  <= 1'b0;
      spi_tx     <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            r_len      <= cmd_len;
            r_byte_idx <= '0;
            r_rx_shift <= '0;
            if (w_len_bad) begin
              // Rejected frame: report immediately, never touch the engine
              r_state   <= ST_ERR;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end else begin
              r_state    <= ST_START;
              spi_enable <= 1'b1;
              spi_start  <= 1'b1;
              spi_tx     <= w_tx_aligned[c_dw-1 -: 8];
              r_tx_buf   <= w_tx_aligned << 8;
              r_hold_cnt <= '0;
            end
          end
        end

        ST_START: begin
          if (r_hold_cnt >= c_hold_last) begin
            spi_start <= 1'b0;
            r_to_cnt  <= '0;
            r_state   <= ST_WAIT;
          end else begin
            r_hold_cnt <= r_hold_cnt + c_hw'(1);
          end
        end

        ST_WAIT: begin
          if (w_fin_rise) begin
            r_state <= ST_CAPTURE;
          end else if (r_to_cnt >= c_to_last) begin
            // Engine never answered: abort with whatever was captured
            r_state    <= ST_ERR;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            rsp_data   <= r_rx_shift;
            spi_enable <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt + c_tw'(1);
          end
        end

        ST_CAPTURE: begin
          r_rx_shift <= w_rx_next;
          r_byte_idx <= r_byte_idx + c_iw'(1);
          if (w_last_byte) begin
            r_state    <= ST_DONE;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b0;
            rsp_data   <= w_rx_next;
            spi_enable <= 1'b0;
          end else begin
            r_gap_cnt <= '0;
            r_state   <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (r_gap_cnt >= c_gap_last) begin
            r_state    <= ST_START;
            spi_start  <= 1'b1;
            spi_tx     <= r_tx_buf[c_dw-1 -: 8];
            r_tx_buf   <= r_tx_buf << 8;
            r_hold_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + c_gw'(1);
          end
        end

        ST_DONE, ST_ERR: begin
          r_state   <= ST_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          r_state    <= ST_IDLE;
          cmd_ready  <= 1'b1;
          busy       <= 1'b0;
          spi_enable <= 1'b0;
          spi_start  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_frame_sequencer.sv
// ============================================================================
// Module      : tb_spi_frame_sequencer
// Description : Self-checking bench for spi_frame_sequencer with a byte-engine
//               model and response / tx-byte scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_frame_sequencer;

  localparam int MAX_BYTES      = 4;
  localparam int START_HOLD     = 8;
  localparam int GAP_CYCLES     = 16;
  localparam int TIMEOUT_CYCLES = 1024;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        mainclk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        spi_enable;
  logic        spi_start;
  logic [7:0]  spi_tx;
  logic [7:0]  spi_rx;
  logic        spi_finish;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rsp_count = 0;
  int   last_rsp_cyc = 0;
  int   starts_seen = 0;
  int   answer_budget = 1000;
  bit   echo_mode = 1'b0;
  bit   glitch_en = 1'b0;
  logic [7:0] fixed_rx = 8'h00;
  logic [7:0] tx_now;

  rsp_t       exp_rsp[$];
  logic [7:0] exp_tx[$];

  always #5 mainclk = ~mainclk;

  always @(posedge mainclk) cyc <= cyc + 1;

  spi_frame_sequencer #(
    .MAX_BYTES      (MAX_BYTES),
    .START_HOLD     (START_HOLD),
    .GAP_CYCLES     (GAP_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .mainclk    (mainclk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .cmd_data   (cmd_data),
    .spi_enable (spi_enable),
    .spi_start  (spi_start),
    .spi_tx     (spi_tx),
    .spi_rx     (spi_rx),
    .spi_finish (spi_finish),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic chk_min(input string name, input int act, input int req);
    tests++;
    if (act < req) begin
      fails++;
      $display("FAIL %s: got %0d, required >= %0d", name, act, req);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, {17'd0, cmd_ready, busy, spi_enable, spi_start, rsp_valid, rsp_err, spi_tx},
        {17'd0, 1'b1, 5'b0, 8'h00});
    chk({name, "_rsp_data"}, rsp_data, 32'h0);
  endtask

  task automatic push_rsp(input logic [31:0] d, input logic e);
    rsp_t r;
    r.data = d;
    r.err  = e;
    exp_rsp.push_back(r);
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge
  task automatic send(input logic [2:0] len, input logic [31:0] data,
                      input bit hold_valid, input bit chk_b2b);
    int n;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 5000) begin
      @(negedge mainclk);
      n++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
    if (chk_b2b) chk("b2b_accept_cycle", cyc, last_rsp_cyc + 1);
    @(negedge mainclk);
    if (!hold_valid) cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_count < target && n < 5000) begin
      @(negedge mainclk);
      n++;
    end
    if (rsp_count < target) chk("rsp_timeout", rsp_count, target);
  endtask

  task automatic respond(input logic [7:0] t);
    repeat (START_HOLD + 5) @(posedge mainclk);
    #3;
    if (reset_n && spi_enable) chk("tx_stable", {24'd0, spi_tx}, {24'd0, t});
    spi_rx     = echo_mode ? (t ^ 8'hFF) : fixed_rx;
    spi_finish = 1'b1;
    repeat (4) @(posedge mainclk);
    #3;
    spi_finish = 1'b0;
    if (glitch_en) begin
      repeat (3) @(posedge mainclk);
      #3;
      spi_finish = 1'b1;
      @(posedge mainclk);
      #3;
      spi_finish = 1'b0;
    end
  endtask

  // Byte engine model: checks each offered byte and answers after a delay
  initial begin
    spi_finish = 1'b0;
    spi_rx     = 8'h00;
    forever begin
      @(posedge spi_start);
      #1;
      starts_seen++;
      tx_now = spi_tx;
      if (exp_tx.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL start_unexpected: got spi_tx %h, required no start", tx_now);
      end else begin
        chk("spi_tx", {24'd0, tx_now}, {24'd0, exp_tx.pop_front()});
      end
      if (answer_budget > 0) begin
        answer_budget--;
        fork
          respond(tx_now);
        join_none
      end
    end
  end

  // Response monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge mainclk);
      if (reset_n && rsp_valid) begin
        rsp_count++;
        last_rsp_cyc = cyc;
        if (exp_rsp.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: got data %h err %b, required none", rsp_data, rsp_err);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        end
      end
    end
  end

  // Start-strobe width and inter-byte spacing monitor
  initial begin
    int  low_cnt;
    int  hi_cnt;
    bit  prev_start;
    bit  prev_en;
    low_cnt = 0; hi_cnt = 0; prev_start = 1'b0; prev_en = 1'b0;
    forever begin
      @(negedge mainclk);
      if (!reset_n) begin
        low_cnt = 0; hi_cnt = 0; prev_start = 1'b0; prev_en = 1'b0;
      end else begin
        if (spi_start) begin
          if (!prev_start && prev_en) chk_min("byte_spacing", low_cnt, GAP_CYCLES + 2);
          hi_cnt++;
          low_cnt = 0;
        end else begin
          if (prev_start) chk("start_hold", hi_cnt, START_HOLD);
          hi_cnt = 0;
          if (spi_enable) low_cnt++;
        end
        prev_start = spi_start;
        prev_en    = spi_enable;
      end
    end
  end

  initial begin
    int base;
    int n;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = 3'd0;
    cmd_data  = 32'h0;
    repeat (3) @(negedge mainclk);
    chk_reset_vals("reset_state");
    reset_n = 1'b1;
    @(negedge mainclk);

    // 1: single byte, fixed answer
    echo_mode = 1'b0;
    fixed_rx  = 8'h3C;
    exp_tx.push_back(8'hA5);
    push_rsp(32'h0000_003C, 1'b0);
    send(3'd1, 32'h0000_00A5, 1'b0, 1'b0);
    chk("start_latency", {31'd0, spi_start}, 32'd1);
    wait_rsp(1);

    // 2: three bytes, echo inverted
    echo_mode = 1'b1;
    exp_tx.push_back(8'h12);
    exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h56);
    push_rsp(32'h00ED_CBA9, 1'b0);
    @(negedge mainclk);
    send(3'd3, 32'h0012_3456, 1'b0, 1'b0);
    wait_rsp(2);

    // 3: illegal lengths
    push_rsp(32'h0, 1'b1);
    @(negedge mainclk);
    send(3'd0, 32'h0000_00AA, 1'b0, 1'b0);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge mainclk);
    end
    chk("busy_len0", n, 1);
    wait_rsp(3);
    push_rsp(32'h0, 1'b1);
    @(negedge mainclk);
    send(3'd5, 32'hFFFF_FFFF, 1'b0, 1'b0);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge mainclk);
    end
    chk("busy_len5", n, 1);
    wait_rsp(4);

    // 4: engine answers first byte only, second byte times out
    answer_budget = 1;
    exp_tx.push_back(8'hBE);
    exp_tx.push_back(8'hEF);
    push_rsp(32'h0000_0041, 1'b1);
    base = starts_seen;
    @(negedge mainclk);
    send(3'd2, 32'h0000_BEEF, 1'b0, 1'b0);
    n = 0;
    while (starts_seen < base + 2 && n < 3000) begin
      @(negedge mainclk);
      n++;
    end
    while (spi_start && n < 3000) begin
      @(negedge mainclk);
      n++;
    end
    n = 1;
    while (!rsp_valid && n < 3000) begin
      @(negedge mainclk);
      n++;
    end
    chk("timeout_cycles", n, TIMEOUT_CYCLES + 1);
    chk("enable_at_err", {31'd0, spi_enable}, 32'd0);
    wait_rsp(5);
    answer_budget = 1000;
    exp_tx.push_back(8'h0F);
    push_rsp(32'h0000_00F0, 1'b0);
    @(negedge mainclk);
    send(3'd1, 32'h0000_000F, 1'b0, 1'b0);
    wait_rsp(6);

    // 5: asynchronous reset during the second byte of a four-byte frame
    exp_tx.push_back(8'h11);
    exp_tx.push_back(8'h22);
    base = starts_seen;
    @(negedge mainclk);
    send(3'd4, 32'h1122_3344, 1'b0, 1'b0);
    n = 0;
    while (starts_seen < base + 2 && n < 3000) begin
      @(negedge mainclk);
      n++;
    end
    repeat (START_HOLD + 2) @(negedge mainclk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midframe_reset");
    repeat (3) @(negedge mainclk);
    reset_n = 1'b1;
    repeat (30) @(negedge mainclk);
    exp_tx.push_back(8'h5C);
    push_rsp(32'h0000_00A3, 1'b0);
    send(3'd1, 32'h0000_005C, 1'b0, 1'b0);
    wait_rsp(7);

    // 6: cmd_valid held high, finish glitches after each byte
    glitch_en = 1'b1;
    exp_tx.push_back(8'hC3);
    exp_tx.push_back(8'h5A);
    push_rsp(32'h0000_3CA5, 1'b0);
    exp_tx.push_back(8'h81);
    push_rsp(32'h0000_007E, 1'b0);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'hFF);
    push_rsp(32'h0000_FF00, 1'b0);
    @(negedge mainclk);
    send(3'd2, 32'h0000_C35A, 1'b1, 1'b0);
    send(3'd1, 32'h0000_0081, 1'b1, 1'b1);
    send(3'd2, 32'h0000_00FF, 1'b0, 1'b1);
    wait_rsp(10);
    glitch_en = 1'b0;
    repeat (40) @(negedge mainclk);

    chk("rsp_queue_left", exp_rsp.size(), 0);
    chk("tx_queue_left", exp_tx.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
